csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode interrupt entry / MRET sequencer driving the CSR write port and PC redirect
module csr_trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc_in,
    input  logic        is_mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mie_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        csr_we_core,
    input  logic [11:0] csr_waddr_core,
    input  logic [31:0] csr_wdata_core,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_STATUS,
        TRAP_JUMP,
        MRET_STATUS,
        MRET_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] mst_q, mst_d;

    logic        ext_pend, tmr_pend, trap_take, mret_take;
    logic [31:0] take_cause, st_trap, st_mret, vec_base;
    logic        csr_we_c, stall_c, redirect_c;
    logic [11:0] csr_waddr_c;
    logic [31:0] csr_wdata_c, pc_target_c;
    logic        unused_bits;

    assign ext_pend   = ext_irq & mie_in[11];
    assign tmr_pend   = timer_irq & mie_in[7];
    assign trap_take  = (state_q == IDLE) && inst_valid && mstatus_in[3] && (ext_pend || tmr_pend);
    assign mret_take  = (state_q == IDLE) && inst_valid && is_mret && !trap_take;
    assign take_cause = ext_pend ? 32'h8000_000B : 32'h8000_0007;
    assign vec_base   = {mtvec_in[31:2], 2'b00};

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.  MRET: MIE <- MPIE, MPIE <- 1.
    always_comb begin
        st_trap        = mst_q;
        st_trap[7]     = mst_q[3];
        st_trap[3]     = 1'b0;
        st_trap[12:11] = 2'b11;
        st_mret        = mst_q;
        st_mret[3]     = mst_q[7];
        st_mret[7]     = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mst_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mst_q   <= mst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        mst_d       = mst_q;
        csr_we_c    = 1'b0;
        csr_waddr_c = '0;
        csr_wdata_c = '0;
        stall_c     = 1'b0;
        redirect_c  = 1'b0;
        pc_target_c = '0;
        unique case (state_q)
            IDLE: begin
                if (trap_take) begin
                    epc_d   = pc_in;
                    cause_d = take_cause;
                    mst_d   = mstatus_in;
                    stall_c = 1'b1;
                    state_d = SAVE_EPC;
                end else if (mret_take) begin
                    mst_d   = mstatus_in;
                    stall_c = 1'b1;
                    state_d = MRET_STATUS;
                end else begin
                    csr_we_c    = csr_we_core;
                    csr_waddr_c = csr_waddr_core;
                    csr_wdata_c = csr_wdata_core;
                end
            end
            SAVE_EPC: begin
                csr_we_c    = 1'b1;
                csr_waddr_c = 12'h341;
                csr_wdata_c = {epc_q[31:2], 2'b00};
                stall_c     = 1'b1;
                state_d     = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_we_c    = 1'b1;
                csr_waddr_c = 12'h342;
                csr_wdata_c = cause_q;
                stall_c     = 1'b1;
                state_d     = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                csr_we_c    = 1'b1;
                csr_waddr_c = 12'h300;
                csr_wdata_c = st_trap;
                stall_c     = 1'b1;
                state_d     = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                redirect_c  = 1'b1;
                pc_target_c = (mtvec_in[1:0] == 2'b01) ? vec_base + {25'd0, cause_q[4:0], 2'b00} : vec_base;
                state_d     = IDLE;
            end
            MRET_STATUS: begin
                csr_we_c    = 1'b1;
                csr_waddr_c = 12'h300;
                csr_wdata_c = st_mret;
                stall_c     = 1'b1;
                state_d     = MRET_JUMP;
            end
            MRET_JUMP: begin
                redirect_c  = 1'b1;
                pc_target_c = mepc_in;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are combinational from live inputs, so reset must mask them explicitly.
    assign csr_we      = csr_we_c & ~rst;
    assign csr_waddr   = rst ? 12'd0 : csr_waddr_c;
    assign csr_wdata   = rst ? 32'd0 : csr_wdata_c;
    assign stall       = stall_c & ~rst;
    assign pc_redirect = redirect_c & ~rst;
    assign pc_target   = rst ? 32'd0 : pc_target_c;
    assign busy        = (state_q != IDLE);

    assign unused_bits = ^{mie_in[31:12], mie_in[10:8], mie_in[6:0], epc_q[1:0]};

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - directed scoreboard bench for csr_trap_ctrl
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid, is_mret, ext_irq, timer_irq, csr_we_core;
    logic [31:0] pc_in, mstatus_in, mie_in, mtvec_in, mepc_in, csr_wdata_core;
    logic [11:0] csr_waddr_core;
    logic        csr_we, stall, pc_redirect, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, pc_target;

    typedef struct {
        bit          jump;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  chk_cnt  = 0;
    int  pass_cnt = 0;

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_in(pc_in), .is_mret(is_mret),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .mstatus_in(mstatus_in), .mie_in(mie_in),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in), .csr_we_core(csr_we_core),
        .csr_waddr_core(csr_waddr_core), .csr_wdata_core(csr_wdata_core),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .stall(stall),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic idle_inputs;
        inst_valid = 0; pc_in = 0; is_mret = 0; ext_irq = 0; timer_irq = 0;
        mstatus_in = 0; mie_in = 0; mtvec_in = 0; mepc_in = 0;
        csr_we_core = 0; csr_waddr_core = 0; csr_wdata_core = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        inst_valid = 1; mstatus_in = 32'h8; mie_in = 32'h80; timer_irq = 1;
        csr_we_core = 1; csr_waddr_core = 12'h305; csr_wdata_core = 32'hABC;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({csr_we, stall, pc_redirect, busy} !== 4'b0000)
            $display("FAIL reset_flags: we/stall/redir/busy=%b required 0000", {csr_we, stall, pc_redirect, busy});
        else pass_cnt++;
        chk_cnt++;
        if (csr_waddr !== 12'd0 || csr_wdata !== 32'd0)
            $display("FAIL reset_csr_bus: addr=%h data=%h required 0/0", csr_waddr, csr_wdata);
        else pass_cnt++;
        chk_cnt++;
        if (pc_target !== 32'd0)
            $display("FAIL reset_target: got %h required 0", pc_target);
        else pass_cnt++;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk_cnt++;
        if ({csr_we, stall, pc_redirect, busy} !== 4'b0000)
            $display("FAIL reset_release: we/stall/redir/busy=%b required 0000", {csr_we, stall, pc_redirect, busy});
        else pass_cnt++;
    endtask

    task automatic test_timer_trap;
        ev_t e;
        @(posedge clk); #1;
        idle_inputs();
        inst_valid = 1; pc_in = 32'h100; mstatus_in = 32'h8; mie_in = 32'h80;
        timer_irq = 1; mtvec_in = 32'h200;
        exp_q.push_back('{0, 12'h341, 32'h0000_0100, 1});
        exp_q.push_back('{0, 12'h342, 32'h8000_0007, 2});
        exp_q.push_back('{0, 12'h300, 32'h0000_1880, 3});
        exp_q.push_back('{1, 12'h000, 32'h0000_0200, 4});
        @(negedge clk);
        chk_cnt++;
        if (stall !== 1'b1 || csr_we !== 1'b0 || busy !== 1'b0)
            $display("FAIL timer_take: stall=%b we=%b busy=%b required 1/0/0", stall, csr_we, busy);
        else pass_cnt++;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            // irq source flips and core writes arrive mid-sequence; neither may disturb it
            inst_valid = 0; timer_irq = 0; ext_irq = 1; mie_in = 32'h880;
            csr_we_core = (c <= 4); csr_waddr_core = 12'h123; csr_wdata_core = 32'hDEAD;
            @(negedge clk);
            if (csr_we || pc_redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0)
                    $display("FAIL timer_event: unexpected cyc=%0d we=%b addr=%h data=%h redir=%b tgt=%h required none",
                             c, csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target);
                else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || (e.jump ? (pc_redirect !== 1'b1 || csr_we !== 1'b0 || pc_target !== e.data)
                                              : (csr_we !== 1'b1 || pc_redirect !== 1'b0 || csr_waddr !== e.addr || csr_wdata !== e.data)))
                        $display("FAIL timer_event: cyc=%0d we=%b addr=%h data=%h redir=%b tgt=%h required cyc=%0d jump=%b addr=%h data=%h",
                                 c, csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target, e.cyc, e.jump, e.addr, e.data);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (stall !== (c <= 3) || busy !== (c <= 4))
                $display("FAIL timer_stall_busy: cyc=%0d stall=%b busy=%b required %b/%b", c, stall, busy, c <= 3, c <= 4);
            else pass_cnt++;
        end
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL timer_drain: %0d events missing, required 0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
        idle_inputs();
    endtask

    task automatic test_simultaneous;
        ev_t e;
        @(posedge clk); #1;
        idle_inputs();
        inst_valid = 1; pc_in = 32'h206; mstatus_in = 32'h8; mie_in = 32'h880;
        ext_irq = 1; timer_irq = 1; mtvec_in = 32'h201;
        exp_q.push_back('{0, 12'h341, 32'h0000_0204, 1});
        exp_q.push_back('{0, 12'h342, 32'h8000_000B, 2});
        exp_q.push_back('{0, 12'h300, 32'h0000_1880, 3});
        exp_q.push_back('{1, 12'h000, 32'h0000_022C, 4});
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            inst_valid = 0;
            @(negedge clk);
            if (csr_we || pc_redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0)
                    $display("FAIL simul_event: unexpected cyc=%0d we=%b addr=%h data=%h redir=%b tgt=%h required none",
                             c, csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target);
                else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || (e.jump ? (pc_redirect !== 1'b1 || csr_we !== 1'b0 || pc_target !== e.data)
                                              : (csr_we !== 1'b1 || pc_redirect !== 1'b0 || csr_waddr !== e.addr || csr_wdata !== e.data)))
                        $display("FAIL simul_event: cyc=%0d we=%b addr=%h data=%h redir=%b tgt=%h required cyc=%0d jump=%b addr=%h data=%h",
                                 c, csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target, e.cyc, e.jump, e.addr, e.data);
                    else pass_cnt++;
                end
            end
        end
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL simul_drain: %0d events missing, required 0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
        idle_inputs();
    endtask

    task automatic test_mret;
        ev_t e;
        @(posedge clk); #1;
        idle_inputs();
        inst_valid = 1; is_mret = 1; mstatus_in = 32'h0000_1880; mepc_in = 32'h104;
        exp_q.push_back('{0, 12'h300, 32'h0000_1888, 1});
        exp_q.push_back('{1, 12'h000, 32'h0000_0104, 2});
        @(negedge clk);
        chk_cnt++;
        if (stall !== 1'b1 || csr_we !== 1'b0)
            $display("FAIL mret_take: stall=%b we=%b required 1/0", stall, csr_we);
        else pass_cnt++;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            inst_valid = 0; is_mret = 0;
            @(negedge clk);
            if (csr_we || pc_redirect) begin
                chk_cnt++;
                if (exp_q.size() == 0)
                    $display("FAIL mret_event: unexpected cyc=%0d we=%b addr=%h data=%h redir=%b tgt=%h required none",
                             c, csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target);
                else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || (e.jump ? (pc_redirect !== 1'b1 || csr_we !== 1'b0 || pc_target !== e.data)
                                              : (csr_we !== 1'b1 || pc_redirect !== 1'b0 || csr_waddr !== e.addr || csr_wdata !== e.data)))
                        $display("FAIL mret_event: cyc=%0d we=%b addr=%h data=%h redir=%b tgt=%h required cyc=%0d jump=%b addr=%h data=%h",
                                 c, csr_we, csr_waddr, csr_wdata, pc_redirect, pc_target, e.cyc, e.jump, e.addr, e.data);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (stall !== (c == 1) || busy !== (c <= 2))
                $display("FAIL mret_stall_busy: cyc=%0d stall=%b busy=%b required %b/%b", c, stall, busy, c == 1, c <= 2);
            else pass_cnt++;
        end
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL mret_drain: %0d events missing, required 0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
        idle_inputs();
    endtask

    task automatic test_core_write;
        int core_hits = 0;
        int redirects = 0;
        @(posedge clk); #1;
        idle_inputs();
        inst_valid = 1; pc_in = 32'h180; mstatus_in = 32'h8; mie_in = 32'h80; timer_irq = 1;
        mtvec_in = 32'h200; csr_we_core = 1; csr_waddr_core = 12'h305; csr_wdata_core = 32'hABC;
        @(negedge clk);
        chk_cnt++;
        if (csr_we !== 1'b0 || stall !== 1'b1)
            $display("FAIL core_drop_take: we=%b stall=%b required 0/1", csr_we, stall);
        else pass_cnt++;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            inst_valid = 0; timer_irq = 0; csr_we_core = (c <= 4);
            @(negedge clk);
            if (csr_we && csr_waddr == 12'h305) core_hits++;
            if (pc_redirect) redirects++;
        end
        chk_cnt++;
        if (core_hits != 0 || redirects != 1)
            $display("FAIL core_drop_seq: core writes=%0d redirects=%0d required 0/1", core_hits, redirects);
        else pass_cnt++;
        @(posedge clk); #1;
        inst_valid = 1; csr_we_core = 1; csr_waddr_core = 12'h305; csr_wdata_core = 32'hABC;
        @(negedge clk);
        chk_cnt++;
        if (csr_we !== 1'b1 || csr_waddr !== 12'h305 || csr_wdata !== 32'hABC || stall !== 1'b0)
            $display("FAIL core_pass: we=%b addr=%h data=%h stall=%b required 1/305/00000abc/0",
                     csr_we, csr_waddr, csr_wdata, stall);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_mie_disabled;
        @(posedge clk); #1;
        idle_inputs();
        inst_valid = 1; mstatus_in = 32'h80; mie_in = 32'h880; ext_irq = 1; timer_irq = 1;
        pc_in = 32'h400; mtvec_in = 32'h200;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_cnt++;
            if ({stall, busy, pc_redirect, csr_we} !== 4'b0000)
                $display("FAIL mie0_no_trap: cyc=%0d stall/busy/redir/we=%b required 0000",
                         c, {stall, busy, pc_redirect, csr_we});
            else pass_cnt++;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        ev_t e;
        int late = 0;
        @(posedge clk); #1;
        idle_inputs();
        inst_valid = 1; pc_in = 32'h300; mstatus_in = 32'h8; mie_in = 32'h80;
        timer_irq = 1; mtvec_in = 32'h400;
        exp_q.push_back('{0, 12'h341, 32'h0000_0300, 1});
        exp_q.push_back('{0, 12'h342, 32'h8000_0007, 2});
        @(negedge clk);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            inst_valid = 0;
            @(negedge clk);
            chk_cnt++;
            if (exp_q.size() == 0)
                $display("FAIL rstmid_event: unexpected cyc=%0d we=%b addr=%h required none", c, csr_we, csr_waddr);
            else begin
                e = exp_q.pop_front();
                if (csr_we !== 1'b1 || csr_waddr !== e.addr || csr_wdata !== e.data)
                    $display("FAIL rstmid_event: cyc=%0d we=%b addr=%h data=%h required 1/%h/%h",
                             c, csr_we, csr_waddr, csr_wdata, e.addr, e.data);
                else pass_cnt++;
            end
        end
        #2 rst = 1;
        #1;
        chk_cnt++;
        if ({busy, stall, csr_we, pc_redirect} !== 4'b0000)
            $display("FAIL rstmid_async: busy/stall/we/redir=%b required 0000", {busy, stall, csr_we, pc_redirect});
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (csr_we || pc_redirect || busy) late++;
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (late != 0)
            $display("FAIL rstmid_quiet: %0d cycles with write/redirect/busy required 0", late);
        else pass_cnt++;
        exp_q.delete();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_timer_trap();
        test_simultaneous();
        test_mret();
        test_core_write();
        test_mie_disabled();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
